// File: rtl/eth_speed_pkg.sv
// Shared encodings, classification/FSM enums and the class-to-speed helper
// used by the multi-channel RGMII link-speed detector.
package eth_speed_pkg;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_10   = 2'd1,
        CLS_100  = 2'd2,
        CLS_1000 = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_PENDING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    // Map a measured class onto the MAC speed encoding; NONE never reaches
    // the outputs, so it maps to the reset speed.
    function automatic logic [1:0] class_to_speed(input cls_e cls);
        logic [1:0] spd;
        case (cls)
            CLS_10:   spd = SPEED_10M;
            CLS_100:  spd = SPEED_100M;
            CLS_1000: spd = SPEED_1000M;
            default:  spd = SPEED_1000M;
        endcase
        return spd;
    endfunction

endpackage

// File: rtl/eth_speed_detect_ch.sv
// One channel of the speed detector: synchroniser, saturating edge counter,
// window classifier and the confirm/commit FSM with its registered outputs.
// Optional override ports are built when ETH_SPEED_DETECT_FORCE_EN is defined.
module eth_speed_detect_ch
    import eth_speed_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 1024,
    parameter int TH_1000         = 128,
    parameter int TH_100          = 16,
    parameter int TH_10           = 2,
    parameter int CONFIRM_WINDOWS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_i,
    input  logic       win_done_i,
    input  logic       tog_i,
`ifdef ETH_SPEED_DETECT_FORCE_EN
    input  logic       force_en_i,
    input  logic [1:0] force_speed_i,
`endif
    output logic [1:0] speed_o,
    output logic       mii_select_o,
    output logic       link_valid_o,
    output logic       speed_change_o
);

    localparam int            CW        = $clog2(WINDOW_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] TH_1000_C = CW'(TH_1000);
    localparam logic [CW-1:0] TH_100_C  = CW'(TH_100);
    localparam logic [CW-1:0] TH_10_C   = CW'(TH_10);
    localparam logic [3:0]    CONF_C    = 4'(CONFIRM_WINDOWS);

    (* srl_style = "register" *) logic [2:0] sync_q;
    logic [CW-1:0] ecnt_q;
    logic [CW-1:0] final_s;
    logic          edge_s;
    cls_e          cls_s;
    logic          commit_s;
    logic [3:0]    confirm_inc_s;

    state_e     state_q;
    cls_e       pend_q;
    cls_e       com_cls_q;
    logic [3:0] confirm_q;
    logic       first_q;
    logic [1:0] com_speed_q;
    logic       com_link_q;
    logic       com_mii_q;
    logic       fsm_change_q;

    // Three-flop synchroniser for the asynchronous prescaler toggle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], tog_i};
        end
    end

    assign edge_s = sync_q[1] ^ sync_q[2];

    // Saturating per-window edge counter, cleared after each window.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ecnt_q <= {CW{1'b0}};
        end else if (restart_i || win_done_i) begin
            ecnt_q <= {CW{1'b0}};
        end else if (edge_s && (ecnt_q != CNT_MAX)) begin
            ecnt_q <= ecnt_q + CNT_ONE;
        end else begin
            ecnt_q <= ecnt_q;
        end
    end

    // Final window count (including a last-cycle edge) and its class.
    always_comb begin
        final_s = ecnt_q;
        if (edge_s && (ecnt_q != CNT_MAX)) begin
            final_s = ecnt_q + CNT_ONE;
        end else begin
            final_s = ecnt_q;
        end
        if (final_s >= TH_1000_C) begin
            cls_s = CLS_1000;
        end else if (final_s >= TH_100_C) begin
            cls_s = CLS_100;
        end else if (final_s >= TH_10_C) begin
            cls_s = CLS_10;
        end else begin
            cls_s = CLS_NONE;
        end
    end

    // Decide whether this window completes a confirmation run.
    always_comb begin
        commit_s      = 1'b0;
        confirm_inc_s = confirm_q + 4'd1;
        if (win_done_i && !restart_i) begin
            case (state_q)
                ST_UNLOCKED: commit_s = (CONF_C == 4'd1);
                ST_PENDING:  commit_s = (cls_s == pend_q) ? (confirm_inc_s == CONF_C)
                                                          : (CONF_C == 4'd1);
                ST_LOCKED:   commit_s = (cls_s != com_cls_q) && (CONF_C == 4'd1);
                default:     commit_s = 1'b0;
            endcase
        end else begin
            commit_s = 1'b0;
        end
    end

    // Confirm/commit FSM; committed outputs change only on a confirmed class.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_UNLOCKED;
            pend_q       <= CLS_NONE;
            confirm_q    <= 4'd0;
            com_cls_q    <= CLS_NONE;
            first_q      <= 1'b1;
            com_speed_q  <= SPEED_1000M;
            com_link_q   <= 1'b0;
            com_mii_q    <= 1'b0;
            fsm_change_q <= 1'b0;
        end else begin
            fsm_change_q <= 1'b0;
            if (restart_i) begin
                state_q   <= ST_UNLOCKED;
                pend_q    <= CLS_NONE;
                confirm_q <= 4'd0;
            end else if (win_done_i) begin
                case (state_q)
                    ST_UNLOCKED: begin
                        pend_q    <= cls_s;
                        confirm_q <= 4'd1;
                        state_q   <= commit_s ? ST_LOCKED : ST_PENDING;
                    end
                    ST_PENDING: begin
                        if (cls_s == pend_q) begin
                            confirm_q <= confirm_inc_s;
                            state_q   <= commit_s ? ST_LOCKED : ST_PENDING;
                        end else begin
                            pend_q    <= cls_s;
                            confirm_q <= 4'd1;
                            state_q   <= commit_s ? ST_LOCKED : ST_PENDING;
                        end
                    end
                    ST_LOCKED: begin
                        if (cls_s != com_cls_q) begin
                            pend_q    <= cls_s;
                            confirm_q <= 4'd1;
                            state_q   <= commit_s ? ST_LOCKED : ST_PENDING;
                        end else begin
                            state_q <= ST_LOCKED;
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
                if (commit_s) begin
                    com_cls_q    <= cls_s;
                    first_q      <= 1'b0;
                    fsm_change_q <= first_q || (cls_s != com_cls_q);
                    if (cls_s == CLS_NONE) begin
                        com_link_q <= 1'b0;
                    end else begin
                        com_link_q  <= 1'b1;
                        com_speed_q <= class_to_speed(cls_s);
                        com_mii_q   <= (cls_s != CLS_1000);
                    end
                end
            end
        end
    end

`ifdef ETH_SPEED_DETECT_FORCE_EN
    logic       force_q;
    logic [1:0] fspd_q;
    logic       rel_change_q;

    // Registered override; flags a change when the override releases onto a different value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            force_q      <= 1'b0;
            fspd_q       <= SPEED_1000M;
            rel_change_q <= 1'b0;
        end else begin
            force_q      <= force_en_i;
            fspd_q       <= force_speed_i;
            rel_change_q <= force_q && !force_en_i &&
                            ((fspd_q != com_speed_q) || !com_link_q);
        end
    end

    assign speed_o        = force_q ? fspd_q : com_speed_q;
    assign link_valid_o   = force_q | com_link_q;
    assign mii_select_o   = force_q ? (fspd_q != SPEED_1000M) : com_mii_q;
    assign speed_change_o = !force_q && (fsm_change_q || rel_change_q);
`else
    assign speed_o        = com_speed_q;
    assign link_valid_o   = com_link_q;
    assign mii_select_o   = com_mii_q;
    assign speed_change_o = fsm_change_q;
`endif

endmodule

// File: rtl/eth_speed_detect_mc.sv
// Multi-channel RGMII link-speed detector: owns the shared measurement
// window and restart, and instantiates one detector per channel.
// Optional macro ETH_SPEED_DETECT_FORCE_EN adds per-channel speed override ports.
module eth_speed_detect_mc
    import eth_speed_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int TH_1000         = 128,
    parameter int TH_100          = 16,
    parameter int TH_10           = 2,
    parameter int CONFIRM_WINDOWS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic [NUM_CH-1:0]     rx_prescale_tog,
`ifdef ETH_SPEED_DETECT_FORCE_EN
    input  logic [NUM_CH-1:0]     force_en,
    input  logic [2*NUM_CH-1:0]   force_speed,
`endif
    output logic [2*NUM_CH-1:0]   speed,
    output logic [NUM_CH-1:0]     mii_select,
    output logic [NUM_CH-1:0]     link_valid,
    output logic [NUM_CH-1:0]     speed_change,
    output logic                  window_done
);

    localparam int            AW           = $clog2(WINDOW_CYCLES);
    localparam logic [AW-1:0] WIN_PRE_LAST = AW'(WINDOW_CYCLES - 2);
    localparam logic [AW-1:0] WIN_ONE      = AW'(1);

    logic [AW-1:0] wcnt_q;
    logic [AW-1:0] wcnt_d;
    logic          win_done_q;
    logic          win_done_d;

    // Next window position; window_done is decoded one cycle early so it is a register.
    always_comb begin
        wcnt_d     = wcnt_q;
        win_done_d = 1'b0;
        if (restart) begin
            wcnt_d     = {AW{1'b0}};
            win_done_d = 1'b0;
        end else begin
            wcnt_d     = wcnt_q + WIN_ONE;
            win_done_d = (wcnt_q == WIN_PRE_LAST);
        end
    end

    // Shared window counter, wrapping naturally at the power-of-two length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q     <= {AW{1'b0}};
            win_done_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            win_done_q <= win_done_d;
        end
    end

    assign window_done = win_done_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        eth_speed_detect_ch #(
            .WINDOW_CYCLES  (WINDOW_CYCLES),
            .TH_1000        (TH_1000),
            .TH_100         (TH_100),
            .TH_10          (TH_10),
            .CONFIRM_WINDOWS(CONFIRM_WINDOWS)
        ) u_ch (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .restart_i     (restart),
            .win_done_i    (win_done_q),
            .tog_i         (rx_prescale_tog[g]),
`ifdef ETH_SPEED_DETECT_FORCE_EN
            .force_en_i    (force_en[g]),
            .force_speed_i (force_speed[2*g +: 2]),
`endif
            .speed_o       (speed[2*g +: 2]),
            .mii_select_o  (mii_select[g]),
            .link_valid_o  (link_valid[g]),
            .speed_change_o(speed_change[g])
        );
    end

endmodule

// File: tb/tb_eth_speed_detect_mc.sv
// Directed bench for eth_speed_detect_mc (default build, 4 channels, 1024-cycle
// window, 3 confirming windows). Toggles are driven on the falling edge;
// a toggle at falling edge m lands as an edge in cycle m+2 of the DUT.
module tb_eth_speed_detect_mc;

    localparam int NUM_CH = 4;
    localparam int WIN    = 1024;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                restart;
    logic [NUM_CH-1:0]   tog;
    logic [2*NUM_CH-1:0] speed;
    logic [NUM_CH-1:0]   mii_select;
    logic [NUM_CH-1:0]   link_valid;
    logic [NUM_CH-1:0]   speed_change;
    logic                window_done;

    int n_cmp = 0;
    int n_err = 0;
    int m;
    int n_pulse;
    int mode [NUM_CH];
    int ivl  [NUM_CH];
    int icnt [NUM_CH];

    always #5 clk = ~clk;

    eth_speed_detect_mc #(
        .NUM_CH         (NUM_CH),
        .WINDOW_CYCLES  (WIN),
        .TH_1000        (128),
        .TH_100         (16),
        .TH_10          (2),
        .CONFIRM_WINDOWS(3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .restart        (restart),
        .rx_prescale_tog(tog),
        .speed          (speed),
        .mii_select     (mii_select),
        .link_valid     (link_valid),
        .speed_change   (speed_change),
        .window_done    (window_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (m=%0d)", tag, act, exp, m);
        end
    endtask

    task automatic set_ch(input int c, input int md, input int iv);
        mode[c] = md;
        ivl[c]  = iv;
        icnt[c] = 0;
    endtask

    // mode 0: idle, 1: toggle every ivl cycles,
    // 2: 16 edges per window (last one in the window_done cycle), 3: 15 edges likewise
    task automatic step();
        @(negedge clk);
        m++;
        for (int c = 0; c < NUM_CH; c++) begin
            int p;
            p = m % WIN;
            case (mode[c])
                1: begin
                    icnt[c]++;
                    if (icnt[c] >= ivl[c]) begin
                        tog[c]  = ~tog[c];
                        icnt[c] = 0;
                    end
                end
                2: if ((p >= 100 && p <= 380 && (p - 100) % 20 == 0) || p == 1021) tog[c] = ~tog[c];
                3: if ((p >= 100 && p <= 360 && (p - 100) % 20 == 0) || p == 1021) tog[c] = ~tog[c];
                default: ;
            endcase
        end
        n_pulse += $countones(speed_change);
    endtask

    task automatic run_to(input int t);
        while (m < t) step();
    endtask

    initial begin
        rst_n   = 1'b0;
        restart = 1'b0;
        tog     = '0;
        m       = 0;
        n_pulse = 0;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_speed", speed, 8'hAA);
        check("rst_link", link_valid, 4'h0);
        check("rst_mii", mii_select, 4'h0);
        check("rst_change", speed_change, 4'h0);
        check("rst_wdone", window_done, 1'b0);

        // ch0 1000M, ch1 100M, ch2 10M, ch3 no clock
        set_ch(0, 1, 4);
        set_ch(1, 1, 20);
        set_ch(2, 1, 200);
        set_ch(3, 0, 0);
        rst_n = 1'b1;

        run_to(1022); check("wdone_1022", window_done, 1'b0);
        run_to(1023); check("wdone_1023", window_done, 1'b1);
        run_to(1024); check("wdone_1024", window_done, 1'b0);

        run_to(3071);
        check("pre_lock_link", link_valid, 4'h0);
        check("pre_lock_speed", speed, 8'hAA);
        check("pre_lock_change", speed_change, 4'h0);
        run_to(3072);
        check("lock_speed", speed, 8'h86);
        check("lock_link", link_valid, 4'b0111);
        check("lock_mii", mii_select, 4'b0110);
        check("lock_change", speed_change, 4'hF);
        set_ch(1, 0, 0);
        run_to(3073); check("lock_change_end", speed_change, 4'h0);

        // ch0 alternates 100M/1000M per window; ch1 lost its clock
        run_to(4096); set_ch(0, 1, 20);
        run_to(5120); set_ch(0, 1, 4);
        run_to(6143);
        check("loss_pre_link", link_valid, 4'b0111);
        check("loss_pre_change", speed_change, 4'h0);
        run_to(6144);
        check("loss_speed", speed, 8'h86);
        check("loss_link", link_valid, 4'b0101);
        check("loss_mii", mii_select, 4'b0110);
        check("loss_change", speed_change, 4'b0010);
        set_ch(0, 1, 20);
        run_to(6145); check("loss_change_end", speed_change, 4'h0);
        run_to(7168);
        check("alt_speed", speed, 8'h86);
        check("alt_link", link_valid, 4'b0101);
        check("alt_change", speed_change, 4'h0);

        // ch1: exactly 16 edges (last in done cycle), ch3: 15 edges
        set_ch(0, 1, 4);
        set_ch(1, 2, 0);
        set_ch(3, 3, 0);
        run_to(10239);
        check("bnd_pre_speed", speed, 8'h86);
        check("bnd_pre_link", link_valid, 4'b0101);
        check("bnd_pre_change", speed_change, 4'h0);
        run_to(10240);
        check("bnd_speed", speed, 8'h06);
        check("bnd_link", link_valid, 4'hF);
        check("bnd_mii", mii_select, 4'b1110);
        check("bnd_change", speed_change, 4'b1010);

        // ch1 goes 1000M, ch3 loses clock; restart lands on the 3rd window_done
        set_ch(1, 1, 4);
        set_ch(3, 0, 0);
        run_to(13311);
        check("rs_wdone", window_done, 1'b1);
        check("rs_pre_speed", speed, 8'h06);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("rs_speed", speed, 8'h06);
        check("rs_link", link_valid, 4'hF);
        check("rs_change", speed_change, 4'h0);
        run_to(14335); check("rs_wdone_next", window_done, 1'b1);
        run_to(16383);
        check("rs_hold_speed", speed, 8'h06);
        check("rs_hold_change", speed_change, 4'h0);
        run_to(16384);
        check("rs_commit_speed", speed, 8'h0A);
        check("rs_commit_link", link_valid, 4'b0111);
        check("rs_commit_mii", mii_select, 4'b1100);
        check("rs_commit_change", speed_change, 4'b1010);
        run_to(16385);
        check("rs_commit_change_end", speed_change, 4'h0);
        check("pulse_total", n_pulse, 9);

        // reset in the middle of a window
        run_to(16884);
        rst_n = 1'b0;
        step();
        check("mid_rst_speed", speed, 8'hAA);
        check("mid_rst_link", link_valid, 4'h0);
        check("mid_rst_mii", mii_select, 4'h0);
        check("mid_rst_change", speed_change, 4'h0);
        check("mid_rst_wdone", window_done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
